// File: rtl/fifo_pkg.sv
// Shared types and elaboration helpers for the circular-buffer FIFO.
package fifo_pkg;

   typedef enum logic [1:0] {
      FIFO_IDLE_OP = 2'd0,
      FIFO_PUSH    = 2'd1,
      FIFO_POP     = 2'd2,
      FIFO_BOTH    = 2'd3
   } fifo_op_e;

   // Occupancy needs one extra bit so that DEPTH itself is representable.
   function automatic int fifo_cw(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic bit fifo_depth_ok(input int depth);
      return (depth >= 2) && ((depth & (depth - 1)) == 0);
   endfunction

   function automatic bit fifo_thresh_ok(input int depth, input int af, input int ae);
      return (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// Flop-array storage: one write port, one registered read port (1-cycle latency).
// The array itself is never reset; only the read register returns to zero.
module fifo_mem #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [WIDTH-1:0]         wr_dat,
   input  logic                     rd_en,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [WIDTH-1:0]         rd_dat
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_dat;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_dat <= '0;
      end else if (rd_en) begin
         rd_dat <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/circ_fifo.sv
// Circular-buffer FIFO: pointers, occupancy, status flags, error pulses; read data 1 cycle after pop.
// Push to a full FIFO is accepted only alongside a pop; rejected requests raise a 1-cycle error pulse.
module circ_fifo
   import fifo_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 16,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 2
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      push_i,
   input  logic [WIDTH-1:0]          data_i,
   input  logic                      pop_i,
   output logic [WIDTH-1:0]          data_o,
   output logic                      rvalid_o,
   output logic                      full_o,
   output logic                      empty_o,
   output logic                      almost_full_o,
   output logic                      almost_empty_o,
   output logic [fifo_cw(DEPTH)-1:0] count_o,
   output logic                      overflow_o,
   output logic                      underflow_o
);

   localparam int CW = fifo_cw(DEPTH);
   localparam int AW = $clog2(DEPTH);

   if (!fifo_depth_ok(DEPTH)) begin : g_bad_depth
      $error("circ_fifo: DEPTH must be a power of two and >= 2");
   end
   if (!fifo_thresh_ok(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_thresh
      $error("circ_fifo: AF_THRESH/AE_THRESH out of range");
   end

   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count_q, count_nxt;
   logic          rvalid_q, overflow_q, underflow_q;
   logic          push_acc, pop_acc;
   fifo_op_e      op;

   // Pop never depends on push, so an empty FIFO cannot fall through.
   assign pop_acc  = pop_i & ~empty_o;
   assign push_acc = push_i & (~full_o | pop_acc);

   always_comb begin
      op = FIFO_IDLE_OP;
      if (push_acc && pop_acc) begin
         op = FIFO_BOTH;
      end else if (push_acc) begin
         op = FIFO_PUSH;
      end else if (pop_acc) begin
         op = FIFO_POP;
      end
   end

   always_comb begin
      count_nxt = count_q;
      case (op)
         FIFO_PUSH: count_nxt = count_q + CW'(1);
         FIFO_POP:  count_nxt = count_q - CW'(1);
         default:   count_nxt = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count_q     <= '0;
         rvalid_q    <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (push_acc) wr_ptr <= wr_ptr + AW'(1);
         if (pop_acc)  rd_ptr <= rd_ptr + AW'(1);
         count_q     <= count_nxt;
         rvalid_q    <= pop_acc;
         overflow_q  <= push_i & ~push_acc;
         underflow_q <= pop_i & ~pop_acc;
      end
   end

   fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .wr_en   (push_acc),
      .wr_addr (wr_ptr),
      .wr_dat  (data_i),
      .rd_en   (pop_acc),
      .rd_addr (rd_ptr),
      .rd_dat  (data_o)
   );

   assign count_o        = count_q;
   assign rvalid_o       = rvalid_q;
   assign overflow_o     = overflow_q;
   assign underflow_o    = underflow_q;
   assign full_o         = (count_q == CW'(DEPTH));
   assign empty_o        = (count_q == '0);
   assign almost_full_o  = (count_q >= CW'(AF_THRESH));
   assign almost_empty_o = (count_q <= CW'(AE_THRESH));

endmodule
